// File: rtl/yout_deserializer.sv
// Serial Yout receiver: rebuilds LSB-first words from single-bit samples
// and queues completed words behind a valid/ready output.
module yout_deserializer #(
    parameter int WORD_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    input  logic                          bit_first,
    input  logic                          clr_ovf,
    output logic [WORD_W-1:0]             word_out,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [$clog2(WORD_W)-1:0]     bit_cnt,
    output logic                          overflow
);

    localparam int CW = $clog2(WORD_W);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]     count_q, count_d;
    logic [WORD_W-1:0] word_out_q, word_out_d;
    logic              overflow_q, overflow_d;

    logic [CW-1:0]     pos;
    logic [WORD_W-1:0] next_word;
    logic [WORD_W-1:0] push_word;
    logic              push;
    logic              pop;
    logic              full;
    logic              push_ok;
    logic              drop;

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        push      = 1'b0;
        push_word = '0;
        pos       = bit_first ? '0 : bit_cnt_q;
        next_word = bit_first ? '0 : shift_q;
        next_word[pos] = bit_in;
        if (bit_valid) begin
            if (pos == CW'(WORD_W - 1)) begin
                push      = 1'b1;
                push_word = next_word;
                shift_d   = '0;
                bit_cnt_d = '0;
            end else begin
                shift_d   = next_word;
                bit_cnt_d = pos + CW'(1);
            end
        end
    end

    // A full FIFO still takes a push when the head leaves on the same edge.
    always_comb begin
        pop      = (count_q != '0) & word_ready;
        full     = (count_q == NW'(FIFO_DEPTH));
        push_ok  = push & (~full | pop);
        drop     = push & full & ~pop;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_word;
        end
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + NW'(push_ok) - NW'(pop);
        word_out_d = word_out_q;
        if (count_d != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
                word_out_d = push_word;
            end else begin
                word_out_d = mem_q[rd_ptr_d];
            end
        end
        overflow_d = drop | (overflow_q & ~clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            word_out_q <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            word_out_q <= word_out_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = (count_q != '0);
    assign fifo_count = count_q;
    assign bit_cnt    = bit_cnt_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_yout_deserializer.sv
// Bench for yout_deserializer: queue-based reference model plus a
// scoreboard monitor that checks every accepted output word.
module tb_yout_deserializer;

    localparam int W  = 4;
    localparam int FD = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         bit_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic         bit_first = 1'b0;
    logic         clr_ovf = 1'b0;
    logic         word_ready = 1'b0;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic [2:0]   fifo_count;
    logic [1:0]   bit_cnt;
    logic         overflow;

    int n_cmp = 0;
    int n_fail = 0;

    bit           bits[$];
    logic [W-1:0] mq[$];
    logic [W-1:0] exp_q[$];
    logic         m_ovf = 1'b0;
    logic [W-1:0] m_out = '0;

    yout_deserializer #(.WORD_W(W), .FIFO_DEPTH(FD)) dut (
        .clk(clk),
        .reset(reset),
        .bit_in(bit_in),
        .bit_valid(bit_valid),
        .bit_first(bit_first),
        .clr_ovf(clr_ovf),
        .word_out(word_out),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .fifo_count(fifo_count),
        .bit_cnt(bit_cnt),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: a handshake seen here completes on the following rising edge.
    always @(negedge clk) begin
        if (!reset && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_word: got %0d expected none (queue empty)", word_out);
            end else begin
                chk("sb_word", word_out, exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic b, input logic v, input logic f,
                        input logic r, input logic c, input logic rst);
        logic         pop_m;
        logic         full_m;
        logic         done;
        logic [W-1:0] w;
        bit_in     = b;
        bit_valid  = v;
        bit_first  = f;
        word_ready = r;
        clr_ovf    = c;
        reset      = rst;
        @(posedge clk);
        if (rst) begin
            bits.delete();
            mq.delete();
            exp_q.delete();
            m_ovf = 1'b0;
            m_out = '0;
        end else begin
            pop_m  = (mq.size() > 0) && r;
            full_m = (mq.size() == FD);
            done   = 1'b0;
            w      = '0;
            if (v) begin
                if (f) bits.delete();
                bits.push_back(b);
                if (bits.size() == W) begin
                    done = 1'b1;
                    foreach (bits[i]) w[i] = bits[i];
                    bits.delete();
                end
            end
            if (pop_m) void'(mq.pop_front());
            if (done && full_m && !pop_m) begin
                m_ovf = 1'b1;
            end else begin
                if (done) begin
                    mq.push_back(w);
                    exp_q.push_back(w);
                end
                if (c) m_ovf = 1'b0;
            end
            if (mq.size() > 0) m_out = mq[0];
        end
        #1;
        chk("bit_cnt", bit_cnt, bits.size());
        chk("fifo_count", fifo_count, mq.size());
        chk("word_valid", word_valid, mq.size() > 0);
        chk("overflow", overflow, m_ovf);
        chk("word_out", word_out, m_out);
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic r_last);
        for (int j = 0; j < W; j++) begin
            step(w[j], 1'b1, j == 0, (j == W - 1) ? r_last : 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idle(input logic r, input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, r, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] nib;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // T1: reset mid-word with two words queued
        send_word(4'h3, 1'b0);
        send_word(4'h9, 1'b0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("t1_pre_cnt", fifo_count, 2);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("t1_cnt", fifo_count, 0);
        chk("t1_valid", word_valid, 0);
        chk("t1_bitcnt", bit_cnt, 0);
        chk("t1_ovf", overflow, 0);

        // T2: basic assembly, one-cycle latency
        step(1, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("t2_valid_pre", word_valid, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("t2_valid", word_valid, 1);
        chk("t2_word", word_out, 4'b1101);
        chk("t2_cnt", fifo_count, 1);
        idle(1'b1, 1);
        chk("t2_hold", word_out, 4'b1101);

        // T3: resync discards partial word
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("t3_bitcnt2", bit_cnt, 2);
        step(0, 1, 1, 0, 0, 0);
        chk("t3_bitcnt1", bit_cnt, 1);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("t3_word", word_out, 4'b0100);
        idle(1'b1, 1);

        // T4: overflow on fifth word, drain order, clear
        for (int i = 1; i <= 5; i++) send_word(W'(i), 1'b0);
        chk("t4_cnt", fifo_count, 4);
        chk("t4_ovf", overflow, 1);
        idle(1'b1, 4);
        chk("t4_empty", word_valid, 0);
        chk("t4_ovf_sticky", overflow, 1);
        step(0, 0, 0, 0, 1, 0);
        chk("t4_clr", overflow, 0);

        // T5: push into full FIFO with same-edge pop
        for (int i = 6; i <= 9; i++) send_word(W'(i), 1'b0);
        send_word(4'hA, 1'b1);
        chk("t5_ovf", overflow, 0);
        chk("t5_cnt", fifo_count, 4);
        idle(1'b1, 5);

        // T6: streaming with consumer always ready
        for (int i = 0; i < 64; i++) begin
            nib = W'($urandom);
            send_word(nib, 1'b1);
            for (int j = 0; j < W - 1; j++) ;
            chk("t6_cnt_le1", fifo_count <= 1, 1);
        end
        chk("t6_ovf", overflow, 0);
        idle(1'b1, 2);

        // Random traffic including clears, resyncs and resets
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
        end
        idle(1'b1, FD + 2);
        chk("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
